// File: rtl/ascon_pack.sv
// Shared types and round primitives for the unrolled Ascon-style permutation.
// Word x0 sits at index 0 of type_state.
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    // Bit positions within the xor_up / xor_down mode fields
    localparam int XUP_DATA = 0;
    localparam int XUP_KEY  = 1;
    localparam int XDN_KEY  = 0;
    localparam int XDN_DSEP = 1;

    // Linear-layer right-rotation pairs, one pair per word
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic type_state add_const(input type_state s, input logic [3:0] r);
        type_state o;
        o    = s;
        o[2] = s[2] ^ {56'h0, round_const(r)};
        return o;
    endfunction

    // Bitsliced 5-bit S-box applied to all 64 columns at once
    function automatic type_state sbox_layer(input type_state s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        type_state   o;
        x0 = s[0] ^ s[4];
        x4 = s[4] ^ s[3];
        x2 = s[2] ^ s[1];
        x1 = s[1];
        x3 = s[3];
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        o[0] = x0;
        o[1] = x1;
        o[2] = x2;
        o[3] = x3;
        o[4] = x4;
        return o;
    endfunction

    function automatic type_state linear_layer(input type_state s);
        type_state o;
        for (int i = 0; i < 5; i++)
            o[i] = s[i] ^ ror64(s[i], ROT_A[i]) ^ ror64(s[i], ROT_B[i]);
        return o;
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One permutation round: constant addition, S-box, linear layer. Purely combinational.
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    assign state_o = linear_layer(sbox_layer(add_const(state_i, round_i)));

endmodule

// File: rtl/permutation_xor_unrolled.sv
// Permutation with input/output XOR stages; UNROLL rounds per enabled cycle,
// round counter r runs from MAX_ROUNDS-n up to MAX_ROUNDS.
module permutation_xor_unrolled
    import ascon_pack::*;
#(
    parameter int UNROLL     = 1,
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic         enable_i,
    input  logic [3:0]   nrounds_i,
    input  type_state    state_i,
    input  logic [127:0] key_i,
    input  logic [63:0]  data_i,
    input  logic [1:0]   xor_up_i,
    input  logic [1:0]   xor_down_i,
    output type_state    state_o,
    output logic         busy_o,
    output logic         done_o
);

    type_state    state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [1:0]   xdn_q, xdn_d;
    logic [3:0]   r_q, r_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    type_state [UNROLL:0] stage;
    type_state            fin;
    type_state            loaded;
    logic [3:0]           n_cl;
    logic                 last;

    assign stage[0] = state_q;

    // Stages whose round index would pass the end pass their input through
    for (genvar i = 0; i < UNROLL; i++) begin : g_stage
        logic [4:0] idx;
        type_state  rnd;
        assign idx = {1'b0, r_q} + 5'(i);
        ascon_round u_round (
            .state_i (stage[i]),
            .round_i (idx[3:0]),
            .state_o (rnd)
        );
        assign stage[i+1] = (idx < 5'(MAX_ROUNDS)) ? rnd : stage[i];
    end

    assign last = ({1'b0, r_q} + 5'(UNROLL)) >= 5'(MAX_ROUNDS);
    assign n_cl = (nrounds_i > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : nrounds_i;

    always_comb begin
        fin = stage[UNROLL];
        if (xdn_q[XDN_KEY]) begin
            fin[3] = fin[3] ^ key_q[127:64];
            fin[4] = fin[4] ^ key_q[63:0];
        end
        if (xdn_q[XDN_DSEP])
            fin[4][0] = ~fin[4][0];
    end

    always_comb begin
        loaded = state_i;
        if (xor_up_i[XUP_DATA])
            loaded[0] = loaded[0] ^ data_i;
        if (xor_up_i[XUP_KEY]) begin
            loaded[1] = loaded[1] ^ key_i[127:64];
            loaded[2] = loaded[2] ^ key_i[63:0];
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        xdn_d   = xdn_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (enable_i) begin
            done_d = 1'b0;
            if (busy_q) begin
                if (last) begin
                    state_d = fin;
                    r_d     = 4'(MAX_ROUNDS);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = stage[UNROLL];
                    r_d     = r_q + 4'(UNROLL);
                end
            end else if (start_i) begin
                state_d = loaded;
                key_d   = key_i;
                xdn_d   = xor_down_i;
                r_d     = 4'(MAX_ROUNDS) - n_cl;
                busy_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= '0;
            key_q   <= '0;
            xdn_q   <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            xdn_q   <= xdn_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign state_o = state_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_permutation_xor_unrolled.sv
// Directed bench: three instances (UNROLL 1/3/4) share stimulus; results are
// checked against a table-driven S-box model and hand-computed latencies.
module tb_permutation_xor_unrolled;
    import ascon_pack::type_state;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    logic         clock_i = 1'b0;
    logic         resetb_i, start_i, enable_i;
    logic [3:0]   nrounds_i;
    type_state    state_i;
    logic [127:0] key_i;
    logic [63:0]  data_i;
    logic [1:0]   xor_up_i, xor_down_i;
    type_state    st1, st3, st4;
    logic         busy1, busy3, busy4, done1, done3, done4;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock_i = ~clock_i;

    permutation_xor_unrolled #(.UNROLL(1)) u1 (
        .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .enable_i(enable_i),
        .nrounds_i(nrounds_i), .state_i(state_i), .key_i(key_i), .data_i(data_i),
        .xor_up_i(xor_up_i), .xor_down_i(xor_down_i),
        .state_o(st1), .busy_o(busy1), .done_o(done1));
    permutation_xor_unrolled #(.UNROLL(3)) u3 (
        .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .enable_i(enable_i),
        .nrounds_i(nrounds_i), .state_i(state_i), .key_i(key_i), .data_i(data_i),
        .xor_up_i(xor_up_i), .xor_down_i(xor_down_i),
        .state_o(st3), .busy_o(busy3), .done_o(done3));
    permutation_xor_unrolled #(.UNROLL(4)) u4 (
        .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .enable_i(enable_i),
        .nrounds_i(nrounds_i), .state_i(state_i), .key_i(key_i), .data_i(data_i),
        .xor_up_i(xor_up_i), .xor_down_i(xor_down_i),
        .state_o(st4), .busy_o(busy4), .done_o(done4));

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic type_state mk(input logic [63:0] x0, x1, x2, x3, x4);
        type_state s;
        s[0] = x0; s[1] = x1; s[2] = x2; s[3] = x3; s[4] = x4;
        return s;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic type_state m_round(input type_state s, input int r);
        type_state t;
        logic [4:0] col, o;
        s[2] = s[2] ^ 64'(((15 - r) << 4) | r);
        for (int b = 0; b < 64; b++) begin
            col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
            o   = SBOX[col];
            t[0][b] = o[4]; t[1][b] = o[3]; t[2][b] = o[2]; t[3][b] = o[1]; t[4][b] = o[0];
        end
        s[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
        s[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
        s[2] = t[2] ^ rotr(t[2], 1)  ^ rotr(t[2], 6);
        s[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
        s[4] = t[4] ^ rotr(t[4], 7)  ^ rotr(t[4], 41);
        return s;
    endfunction

    function automatic type_state model(input type_state st, input int n, input logic [127:0] k,
                                        input logic [63:0] d, input logic [1:0] xu, xd);
        type_state s = st;
        int nn = (n > 12) ? 12 : n;
        if (xu[0]) s[0] = s[0] ^ d;
        if (xu[1]) begin s[1] = s[1] ^ k[127:64]; s[2] = s[2] ^ k[63:0]; end
        for (int r = 12 - nn; r < 12; r++) s = m_round(s, r);
        if (xd[0]) begin s[3] = s[3] ^ k[127:64]; s[4] = s[4] ^ k[63:0]; end
        if (xd[1]) s[4][0] = ~s[4][0];
        return s;
    endfunction

    // Called just after a sampling point; stall covers edges [stall_from, stall_from+stall_len)
    task automatic run(input string tag, input int n, input type_state st, input logic [127:0] k,
                       input logic [63:0] d, input logic [1:0] xu, xd,
                       input int stall_from, stall_len, bogus_at, exp1, exp3, exp4);
        type_state exp_s;
        int l1 = -1, l3 = -1, l4 = -1;
        int c1 = 0, c3 = 0, c4 = 0;
        int last_lat;
        exp_s = model(st, n, k, d, xu, xd);
        last_lat = (exp1 > exp3) ? exp1 : exp3;
        last_lat = (last_lat > exp4) ? last_lat : exp4;
        start_i = 1'b1; enable_i = 1'b1; nrounds_i = 4'(n); state_i = st;
        key_i = k; data_i = d; xor_up_i = xu; xor_down_i = xd;
        @(posedge clock_i); #1;
        start_i = 1'b0;
        state_i = mk(64'hdead, 64'hbeef, 64'h1234, 64'h5678, 64'h9abc);
        chk({tag, "_busy"}, {busy1, busy3, busy4}, 3'b111);
        for (int e = 1; e <= 40; e++) begin
            enable_i = !(e >= stall_from && e < stall_from + stall_len);
            start_i  = (e == bogus_at);
            @(posedge clock_i); #1;
            start_i = 1'b0;
            if (enable_i) begin
                if (done1) begin c1++; if (l1 < 0) l1 = e; end
                if (done3) begin c3++; if (l3 < 0) l3 = e; end
                if (done4) begin c4++; if (l4 < 0) l4 = e; end
            end
            if (e > last_lat + 1) break;
        end
        enable_i = 1'b1;
        chk({tag, "_lat1"}, 320'(l1), 320'(exp1));
        chk({tag, "_lat3"}, 320'(l3), 320'(exp3));
        chk({tag, "_lat4"}, 320'(l4), 320'(exp4));
        chk({tag, "_pulses"}, {8'(c1), 8'(c3), 8'(c4)}, {8'd1, 8'd1, 8'd1});
        chk({tag, "_st1"}, st1, exp_s);
        chk({tag, "_st3"}, st3, exp_s);
        chk({tag, "_st4"}, st4, exp_s);
        repeat (3) @(posedge clock_i);
        #1;
        chk({tag, "_hold"}, st1, exp_s);
    endtask

    type_state    s_init, s_data;
    logic [127:0] key;
    int           seen;

    initial begin
        resetb_i = 1'b0; start_i = 1'b0; enable_i = 1'b1; nrounds_i = '0;
        state_i = '0; key_i = '0; data_i = '0; xor_up_i = '0; xor_down_i = '0;
        key    = 128'h0001020304050607_08090a0b0c0d0e0f;
        s_init = mk(64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
                    64'h1011121314151617, 64'h18191a1b1c1d1e1f);
        s_data = mk(64'h1b1354db77e0dbb4, 64'h6f140401cfa0873c, 64'hd7e8abaf45f2885a,
                    64'hc0c5777fa661625e, 64'hfc4374d28210928c);
        repeat (2) @(posedge clock_i);
        #1;
        chk("rst_state", {st1, st3, st4}, '0);
        chk("rst_ctrl", {busy1, done1, busy3, done3, busy4, done4}, 6'b0);
        resetb_i = 1'b1;
        @(posedge clock_i); #1;

        run("init",  12, s_init, key, 64'h0, 2'b00, 2'b01, 0, 0, 0, 12, 4, 3);
        run("data",   6, s_data, key, 64'h3230323380000000, 2'b01, 2'b10, 0, 0, 0, 6, 2, 2);
        run("stall", 12, s_init, key, 64'h0, 2'b00, 2'b01, 2, 3, 5, 15, 7, 6);
        run("clamp", 15, s_init, key, 64'h0, 2'b10, 2'b11, 0, 0, 0, 12, 4, 3);

        // Reset in the middle of a run: outputs clear at once, no done afterwards
        start_i = 1'b1; nrounds_i = 4'd12; state_i = s_init; xor_down_i = 2'b01;
        @(posedge clock_i); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clock_i);
        #2;
        resetb_i = 1'b0;
        #1;
        chk("midrst_state", {st1, st3, st4}, '0);
        chk("midrst_ctrl", {busy1, done1, busy3, done3, busy4, done4}, 6'b0);
        @(posedge clock_i); #1;
        resetb_i = 1'b1;
        seen = 0;
        for (int e = 0; e < 16; e++) begin
            @(posedge clock_i); #1;
            if (done1 || done3 || done4 || busy1 || busy3 || busy4) seen++;
        end
        chk("midrst_quiet", 320'(seen), 320'(0));

        run("n0", 0, s_data, key, 64'h0, 2'b00, 2'b01, 0, 0, 0, 1, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
